instr_mem_ctrl: RTL and testbench

Parametrised, loadable instruction memory for the MIPS core's fetch stage. Holds DEPTH words of INSTR_W bits, serves byte-addressed PC fetches with one-cycle registered latency, and flags misaligned, negative or out-of-range PCs by returning a fixed invalid opcode. After reset it self-clears to the invalid opcode. A serial load port writes a program at runtime, so test programs no longer need to be hard-coded.

---
 rtl/imem_pkg.sv | 42 ++++
 rtl/imem_array.sv | 37 +++
 rtl/instr_mem_ctrl.sv | 159 +++++++++++++++
 tb/tb_instr_mem_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types, constants and the PC fault check for the instruction memory.
package imem_pkg;

    // Controller state
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } imem_state_e;

    // Opcode 6'b111111 with all other fields zero: returned for faults and cleared words
    localparam logic [31:0] IMEM_INVALID_INSTR = 32'hFC00_0000;

    // Widest PC the fault check accepts; narrower PCs are zero-extended
    localparam int unsigned PC_W_MAX = 64;

    // A PC faults when it is not word aligned, or when any bit above the word
    // index is set (which also covers a set sign bit). Bits at or beyond pc_w
    // are ignored.
    function automatic logic fetch_fault_f(
        input logic [PC_W_MAX-1:0] pc,
        input int unsigned         pc_w,
        input int unsigned         depth
    );
        int unsigned idx_w;
        logic        f;
        idx_w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(depth)) begin
                idx_w = i + 1;
            end
        end
        f = (pc[1:0] != 2'b00);
        for (int unsigned i = 0; i < PC_W_MAX; i++) begin
            if ((i >= idx_w + 2) && (i < pc_w) && pc[i]) begin
                f = 1'b1;
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Single-port instruction RAM: synchronous write, registered read with enable.
module imem_array #(
    parameter int unsigned   W       = 32,
    parameter int unsigned   DEPTH   = 128,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [W-1:0]             i_wdata,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    // Storage write; contents are not reset, the controller clears them explicitly
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register only updates on a read, so the last fetched word is held
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= RST_VAL;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Loadable instruction memory for the fetch stage: self-clears after reset,
// serves byte-addressed fetches with one-cycle latency, and accepts a serial
// program load at runtime.
module instr_mem_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned         INSTR_W       = 32,
    parameter int unsigned         DEPTH         = 128,
    parameter int unsigned         PC_W          = 32,
    parameter logic [INSTR_W-1:0]  INVALID_INSTR = INSTR_W'(IMEM_INVALID_INSTR)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_req,
    input  logic [PC_W-1:0]              fetch_pc,
    output logic                         fetch_valid,
    output logic [INSTR_W-1:0]           fetch_instr,
    output logic                         fetch_fault,
    output logic                         busy,
    input  logic                         load_start,
    input  logic                         load_valid,
    input  logic [INSTR_W-1:0]           load_data,
    input  logic                         load_last,
    output logic                         load_ready,
    output logic [$clog2(DEPTH+1)-1:0]   load_count,
    output logic                         load_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    imem_state_e          r_state;
    logic [AW-1:0]        r_clr_idx;
    logic [CW-1:0]        r_load_cnt;
    logic                 r_load_ovf;
    logic                 r_fetch_valid;
    logic                 r_fault;

    logic [AW-1:0]        w_fetch_idx;
    logic                 w_fetch_fault;
    logic                 w_fetch_fire;
    logic                 w_load_beat;
    logic                 w_load_wr;
    logic                 w_mem_we;
    logic                 w_mem_re;
    logic [AW-1:0]        w_mem_addr;
    logic [INSTR_W-1:0]   w_mem_wdata;
    logic [INSTR_W-1:0]   w_mem_rdata;

    // Fetch decode; load_start in RUN takes priority and drops a same-cycle fetch
    assign w_fetch_idx   = fetch_pc[AW+1:2];
    assign w_fetch_fault = fetch_fault_f(PC_W_MAX'(fetch_pc), PC_W, DEPTH);
    assign w_fetch_fire  = (r_state == RUN) && fetch_req && !load_start;

    // A load beat counts only in LOAD and not in a restart cycle; it writes only while room remains
    assign w_load_beat = (r_state == LOAD) && load_valid && !load_start;
    assign w_load_wr   = w_load_beat && (r_load_cnt < DEPTH_CNT);

    // Single RAM port shared between clear index, load pointer and fetch index
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_mem_addr  = w_fetch_idx;
        w_mem_wdata = INVALID_INSTR;
        case (r_state)
            CLEAR: begin
                w_mem_we   = !reset;
                w_mem_addr = r_clr_idx;
            end
            LOAD: begin
                w_mem_we    = w_load_wr && !reset;
                w_mem_addr  = r_load_cnt[AW-1:0];
                w_mem_wdata = load_data;
            end
            RUN: begin
                w_mem_re = w_fetch_fire;
            end
            default: begin
                w_mem_we = 1'b0;
            end
        endcase
    end

    // Controller state, load bookkeeping and fetch result flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= CLEAR;
            r_clr_idx     <= '0;
            r_load_cnt    <= '0;
            r_load_ovf    <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch_fire;
            if (w_fetch_fire) begin
                r_fault <= w_fetch_fault;
            end
            case (r_state)
                CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == LAST_IDX) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (load_start) begin
                        r_state    <= LOAD;
                        r_load_cnt <= '0;
                        r_load_ovf <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        r_load_cnt <= '0;
                        r_load_ovf <= 1'b0;
                    end else if (load_valid) begin
                        if (r_load_cnt < DEPTH_CNT) begin
                            r_load_cnt <= r_load_cnt + 1'b1;
                        end else begin
                            r_load_ovf <= 1'b1;
                        end
                        if (load_last) begin
                            r_state <= RUN;
                        end
                    end
                end
                default: begin
                    r_state <= CLEAR;
                end
            endcase
        end
    end

    imem_array #(
        .W       (INSTR_W),
        .DEPTH   (DEPTH),
        .RST_VAL (INVALID_INSTR)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    // Output mapping; fetch_instr holds its last value between fetch results
    assign fetch_valid   = r_fetch_valid;
    assign fetch_fault   = r_fault && r_fetch_valid;
    assign fetch_instr   = r_fault ? INVALID_INSTR : w_mem_rdata;
    assign busy          = (r_state != RUN);
    assign load_ready    = (r_state == LOAD);
    assign load_count    = r_load_cnt;
    assign load_overflow = r_load_ovf;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed self-checking bench for instr_mem_ctrl.
module tb_instr_mem_ctrl;

    localparam logic [31:0] INV = 32'hFC00_0000;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_fault;
    logic        busy;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic [7:0]  load_count;
    logic        load_overflow;

    int n_assert;
    int n_fail;
    int cyc;

    instr_mem_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_req     (fetch_req),
        .fetch_pc      (fetch_pc),
        .fetch_valid   (fetch_valid),
        .fetch_instr   (fetch_instr),
        .fetch_fault   (fetch_fault),
        .busy          (busy),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .load_count    (load_count),
        .load_overflow (load_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle so outputs of that edge are visible
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Drive a fetch, then check the result visible after the sampling edge
    task automatic fetch_chk(input string tag, input logic [31:0] pc,
                             input logic [31:0] exp_instr, input logic exp_fault);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        tick();
        fetch_req = 1'b0;
        chk({tag, "_valid"}, 32'(fetch_valid), 32'd1);
        chk({tag, "_instr"}, fetch_instr, exp_instr);
        chk({tag, "_fault"}, 32'(fetch_fault), 32'(exp_fault));
    endtask

    // Wait for CLEAR to finish, counting busy cycles after reset release
    task automatic wait_clear(input string tag);
        cyc = 0;
        while (busy && cyc < 300) begin
            tick();
            cyc++;
        end
        chk(tag, 32'(cyc), 32'd128);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        fetch_req  = 1'b0;
        fetch_pc   = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
        chk("rst_fetch_instr", fetch_instr, INV);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_load_count", 32'(load_count), 32'd0);
        chk("rst_load_ovf", 32'(load_overflow), 32'd0);

        // Self-clear, fetch ignored while busy
        reset     = 1'b0;
        fetch_req = 1'b1;
        wait_clear("clear_cycles");
        fetch_req = 1'b0;
        tick();
        chk("idle_valid", 32'(fetch_valid), 32'd0);
        fetch_chk("f_clr0", 32'h0, INV, 1'b0);
        tick();
        chk("f_clr0_after_valid", 32'(fetch_valid), 32'd0);

        // Three-word load; load_valid in the load_start cycle is ignored
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        tick();
        load_start = 1'b0;
        chk("ld3_ready", 32'(load_ready), 32'd1);
        chk("ld3_busy", 32'(busy), 32'd1);
        chk("ld3_cnt0", 32'(load_count), 32'd0);
        load_data = 32'h8C10_0000;
        tick();
        load_data = 32'h8C11_0004;
        tick();
        load_data = 32'h0211_9020;
        load_last = 1'b1;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("ld3_count", 32'(load_count), 32'd3);
        chk("ld3_busy_low", 32'(busy), 32'd0);
        chk("ld3_ready_low", 32'(load_ready), 32'd0);
        chk("ld3_ovf", 32'(load_overflow), 32'd0);

        // Back-to-back fetches of the loaded program
        fetch_chk("f_w0", 32'h0, 32'h8C10_0000, 1'b0);
        fetch_chk("f_w1", 32'h4, 32'h8C11_0004, 1'b0);
        fetch_chk("f_w2", 32'h8, 32'h0211_9020, 1'b0);
        tick();
        chk("hold_valid", 32'(fetch_valid), 32'd0);
        chk("hold_instr", fetch_instr, 32'h0211_9020);

        // Fault conditions
        fetch_chk("f_misalign", 32'h6, INV, 1'b1);
        fetch_chk("f_range", 32'h200, INV, 1'b1);
        fetch_chk("f_neg", 32'h8000_0000, INV, 1'b1);
        fetch_chk("f_last", 32'h1FC, INV, 1'b0);
        fetch_chk("f_w1_again", 32'h4, 32'h8C11_0004, 1'b0);

        // 130-word load overflows by two
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 130; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h1000_0000 + 32'(i);
            load_last  = (i == 129);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("ovf_count", 32'(load_count), 32'd128);
        chk("ovf_flag", 32'(load_overflow), 32'd1);
        chk("ovf_busy", 32'(busy), 32'd0);
        fetch_chk("ovf_w0", 32'h0, 32'h1000_0000, 1'b0);
        fetch_chk("ovf_w127", 32'h1FC, 32'h1000_007F, 1'b0);
        fetch_chk("ovf_w2", 32'h8, 32'h1000_0002, 1'b0);

        // load_start together with fetch_req drops the fetch
        load_start = 1'b1;
        fetch_req  = 1'b1;
        fetch_pc   = 32'h0;
        tick();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        chk("drop_valid", 32'(fetch_valid), 32'd0);
        chk("drop_ready", 32'(load_ready), 32'd1);
        chk("drop_ovf_clr", 32'(load_overflow), 32'd0);
        chk("drop_cnt_clr", 32'(load_count), 32'd0);

        // Two beats, restart in LOAD, one more beat, then reset mid-load
        load_valid = 1'b1;
        load_data  = 32'hAAAA_0000;
        tick();
        load_data  = 32'hAAAA_0001;
        tick();
        chk("mid_count2", 32'(load_count), 32'd2);
        load_start = 1'b1;
        load_data  = 32'hBBBB_BBBB;
        tick();
        load_start = 1'b0;
        chk("restart_count", 32'(load_count), 32'd0);
        load_data = 32'hAAAA_0002;
        tick();
        load_valid = 1'b0;
        chk("restart_count1", 32'(load_count), 32'd1);
        chk("restart_busy", 32'(busy), 32'd1);

        reset = 1'b1;
        tick();
        chk("rst2_count", 32'(load_count), 32'd0);
        chk("rst2_ready", 32'(load_ready), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        wait_clear("clear2_cycles");
        fetch_chk("f_after_rst0", 32'h0, INV, 1'b0);
        fetch_chk("f_after_rst1", 32'h4, INV, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
